// File: rtl/ibuf_dbuf.sv
// Ping-pong systolic input buffer: the memory side fills one tag while the PE array drains the other.
// Optional dropped-request counter on err_count is enabled by defining IBUF_DBUF_ERR_CNT_EN.

module ibuf_dbuf_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [1:0] i_st0,
    input logic [1:0] i_st1,
    input logic       i_wr_tag,
    input logic       i_rd_tag,
    input logic       i_wr_ready,
    input logic       i_rd_ready
);
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [1:0] w_st_wr;
    logic [1:0] w_st_rd;

    assign w_st_wr = i_wr_tag ? i_st1 : i_st0;
    assign w_st_rd = i_rd_tag ? i_st1 : i_st0;

    a_single_fill: assert property (@(posedge clk) disable iff (!rst_n)
        !((i_st0 == ST_FILL) && (i_st1 == ST_FILL)));
    a_wr_ready: assert property (@(posedge clk) disable iff (!rst_n)
        i_wr_ready == (w_st_wr != ST_FULL));
    a_rd_ready: assert property (@(posedge clk) disable iff (!rst_n)
        i_rd_ready == (w_st_rd == ST_FULL));
endmodule

module ibuf_dbuf #(
    parameter int MEM_DATA_WIDTH  = 64,
    parameter int ARRAY_N         = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int BUF_ADDR_WIDTH  = 10,
    localparam int GROUP_SIZE     = MEM_DATA_WIDTH / DATA_WIDTH,
    localparam int NUM_GROUPS     = ARRAY_N / GROUP_SIZE,
    localparam int BUF_ID_W       = $clog2(NUM_GROUPS),
    localparam int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mem_write_req,
    input  logic [MEM_ADDR_WIDTH-1:0]     mem_write_addr,
    input  logic [MEM_DATA_WIDTH-1:0]     mem_write_data,
    output logic                          mem_write_ready,
    input  logic                          mem_fill_done,
    input  logic                          buf_read_req,
    input  logic [BUF_ADDR_WIDTH-1:0]     buf_read_addr,
    output logic [ARRAY_N*DATA_WIDTH-1:0] buf_read_data,
    output logic [ARRAY_N-1:0]            buf_read_valid,
    output logic                          rd_bank_ready,
    input  logic                          buf_drain_done,
    output logic [15:0]                   err_count
);
    localparam int BUF_ID_WS = (BUF_ID_W > 0) ? BUF_ID_W : 1;
    localparam int RAM_WORDS = 2 ** (BUF_ADDR_WIDTH + 1);

    typedef enum logic [1:0] {
        TAG_EMPTY = 2'd0,
        TAG_FILL  = 2'd1,
        TAG_FULL  = 2'd2
    } tag_state_e;

    tag_state_e r_tag_st     [2];
    tag_state_e w_tag_st_nxt [2];
    logic       r_wr_tag;
    logic       r_rd_tag;
    logic       w_wr_tag_nxt;
    logic       w_rd_tag_nxt;
    logic       r_wr_ready;
    logic       r_rd_ready;
    logic       w_wr_ready_nxt;
    logic       w_rd_ready_nxt;

    logic w_wr_acc;
    logic w_rd_acc;
    logic w_fill;
    logic w_drain;

    logic [BUF_ADDR_WIDTH-1:0] w_wr_word;
    logic [BUF_ID_WS-1:0]      w_buf_id;
    logic [ARRAY_N-1:0]        w_lane_we;

    logic [ARRAY_N-1:0]        r_rq_vld;
    logic [ARRAY_N-1:0]        r_rq_tag;
    logic [BUF_ADDR_WIDTH-1:0] r_rq_addr [ARRAY_N];

    assign w_wr_acc = mem_write_req & r_wr_ready;
    assign w_rd_acc = buf_read_req & r_rd_ready;
    assign w_fill   = mem_fill_done & r_wr_ready;
    assign w_drain  = buf_drain_done & r_rd_ready;

    assign mem_write_ready = r_wr_ready;
    assign rd_bank_ready   = r_rd_ready;

    // Tag ownership next-state: fill_done and drain_done never target the same tag.
    always_comb begin
        for (int t = 0; t < 2; t++) begin
            w_tag_st_nxt[t] = r_tag_st[t];
            case (r_tag_st[t])
                TAG_EMPTY: begin
                    if (w_fill && (r_wr_tag == 1'(t))) begin
                        w_tag_st_nxt[t] = TAG_FULL;
                    end else if (w_wr_acc && (r_wr_tag == 1'(t))) begin
                        w_tag_st_nxt[t] = TAG_FILL;
                    end else begin
                        w_tag_st_nxt[t] = TAG_EMPTY;
                    end
                end
                TAG_FILL: begin
                    if (w_fill && (r_wr_tag == 1'(t))) begin
                        w_tag_st_nxt[t] = TAG_FULL;
                    end else begin
                        w_tag_st_nxt[t] = TAG_FILL;
                    end
                end
                TAG_FULL: begin
                    if (w_drain && (r_rd_tag == 1'(t))) begin
                        w_tag_st_nxt[t] = TAG_EMPTY;
                    end else begin
                        w_tag_st_nxt[t] = TAG_FULL;
                    end
                end
                default: w_tag_st_nxt[t] = TAG_EMPTY;
            endcase
        end
        w_wr_tag_nxt = r_wr_tag;
        w_rd_tag_nxt = r_rd_tag;
        if (w_fill) begin
            w_wr_tag_nxt = ~r_wr_tag;
        end else begin
            w_wr_tag_nxt = r_wr_tag;
        end
        if (w_drain) begin
            w_rd_tag_nxt = ~r_rd_tag;
        end else begin
            w_rd_tag_nxt = r_rd_tag;
        end
    end

    assign w_wr_ready_nxt = (w_tag_st_nxt[w_wr_tag_nxt] != TAG_FULL);
    assign w_rd_ready_nxt = (w_tag_st_nxt[w_rd_tag_nxt] == TAG_FULL);

    // Tag state, tag pointers and handshake readies.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag_st[0] <= TAG_EMPTY;
            r_tag_st[1] <= TAG_EMPTY;
            r_wr_tag    <= 1'b0;
            r_rd_tag    <= 1'b0;
            r_wr_ready  <= 1'b1;
            r_rd_ready  <= 1'b0;
        end else begin
            r_tag_st[0] <= w_tag_st_nxt[0];
            r_tag_st[1] <= w_tag_st_nxt[1];
            r_wr_tag    <= w_wr_tag_nxt;
            r_rd_tag    <= w_rd_tag_nxt;
            r_wr_ready  <= w_wr_ready_nxt;
            r_rd_ready  <= w_rd_ready_nxt;
        end
    end

    // buf_id lives in the address LSBs; with a single lane group every lane is written.
    assign w_wr_word = mem_write_addr[MEM_ADDR_WIDTH-1:BUF_ID_W];
    if (BUF_ID_W > 0) begin : g_bid
        assign w_buf_id = mem_write_addr[BUF_ID_WS-1:0];
    end else begin : g_nobid
        assign w_buf_id = 1'b0;
    end

    // Request wavefront: lane n sees lane 0's request n cycles later, carrying its own tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rq_vld <= '0;
            r_rq_tag <= '0;
            for (int n = 0; n < ARRAY_N; n++) begin
                r_rq_addr[n] <= '0;
            end
        end else begin
            r_rq_vld[0]  <= w_rd_acc;
            r_rq_tag[0]  <= r_rd_tag;
            r_rq_addr[0] <= buf_read_addr;
            for (int n = 1; n < ARRAY_N; n++) begin
                r_rq_vld[n]  <= r_rq_vld[n-1];
                r_rq_tag[n]  <= r_rq_tag[n-1];
                r_rq_addr[n] <= r_rq_addr[n-1];
            end
        end
    end

    for (genvar n = 0; n < ARRAY_N; n++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_mem [RAM_WORDS];
        logic [DATA_WIDTH-1:0] r_rd_data;
        logic                  r_rd_vld;

        assign w_lane_we[n] = w_wr_acc && (w_buf_id == BUF_ID_WS'(n / GROUP_SIZE));

        // Lane RAM write port, addressed {tag, word}.
        always_ff @(posedge clk) begin
            if (w_lane_we[n]) begin
                r_mem[{r_wr_tag, w_wr_word}] <= mem_write_data[(n % GROUP_SIZE)*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Lane RAM output register; data holds while no request reaches this lane.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_rd_data <= '0;
                r_rd_vld  <= 1'b0;
            end else begin
                r_rd_vld <= r_rq_vld[n];
                if (r_rq_vld[n]) begin
                    r_rd_data <= r_mem[{r_rq_tag[n], r_rq_addr[n]}];
                end
            end
        end

        assign buf_read_data[n*DATA_WIDTH +: DATA_WIDTH] = r_rd_data;
        assign buf_read_valid[n] = r_rd_vld;
    end

`ifdef IBUF_DBUF_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;

    assign w_err_inc = {1'b0, mem_write_req & ~r_wr_ready} + {1'b0, buf_read_req & ~r_rd_ready};
    assign w_err_sum = {1'b0, r_err_cnt} + {15'd0, w_err_inc};

    // Saturating count of requests dropped for lack of ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_cnt <= 16'd0;
        end else begin
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = 16'd0;
`endif

    ibuf_dbuf_chk u_chk (
        .clk        (clk),
        .rst_n      (reset),
        .i_st0      (r_tag_st[0]),
        .i_st1      (r_tag_st[1]),
        .i_wr_tag   (r_wr_tag),
        .i_rd_tag   (r_rd_tag),
        .i_wr_ready (r_wr_ready),
        .i_rd_ready (r_rd_ready)
    );
endmodule

// File: tb/tb_ibuf_dbuf.sv
// Randomized bench for ibuf_dbuf against a tag-ownership/memory reference model,
// plus directed scenarios and a GROUP_SIZE=2 instance for lane-group writes.

module tb_ibuf_dbuf;
    localparam int AN = 4;
    localparam int DW = 16;

`ifdef IBUF_DBUF_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        mem_write_req;
    logic [9:0]  mem_write_addr;
    logic [63:0] mem_write_data;
    logic        mem_write_ready;
    logic        mem_fill_done;
    logic        buf_read_req;
    logic [9:0]  buf_read_addr;
    logic [63:0] buf_read_data;
    logic [3:0]  buf_read_valid;
    logic        rd_bank_ready;
    logic        buf_drain_done;
    logic [15:0] err_count;

    logic        u2_wreq;
    logic [10:0] u2_waddr;
    logic [31:0] u2_wdata;
    logic        u2_wready;
    logic        u2_fill;
    logic        u2_rreq;
    logic [9:0]  u2_raddr;
    logic [63:0] u2_rdata;
    logic [3:0]  u2_rvalid;
    logic        u2_rready;
    logic        u2_drain;
    logic [15:0] u2_err;

    ibuf_dbuf u_dut (
        .clk(clk), .reset(reset),
        .mem_write_req(mem_write_req), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .mem_fill_done(mem_fill_done), .buf_read_req(buf_read_req),
        .buf_read_addr(buf_read_addr), .buf_read_data(buf_read_data),
        .buf_read_valid(buf_read_valid), .rd_bank_ready(rd_bank_ready),
        .buf_drain_done(buf_drain_done), .err_count(err_count)
    );

    ibuf_dbuf #(.MEM_DATA_WIDTH(32)) u_dut2 (
        .clk(clk), .reset(reset),
        .mem_write_req(u2_wreq), .mem_write_addr(u2_waddr),
        .mem_write_data(u2_wdata), .mem_write_ready(u2_wready),
        .mem_fill_done(u2_fill), .buf_read_req(u2_rreq),
        .buf_read_addr(u2_raddr), .buf_read_data(u2_rdata),
        .buf_read_valid(u2_rvalid), .rd_bank_ready(u2_rready),
        .buf_drain_done(u2_drain), .err_count(u2_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: which tags hold a complete tile, where each side points, memory image.
    typedef struct { int cyc; int addr; bit tag; } rq_t;
    logic [15:0] m_mem   [2][AN][1024];
    bit          m_known [2][AN][1024];
    bit          m_full  [2];
    bit          m_wr;
    bit          m_rd;
    int          m_err;
    int          edge_n;
    rq_t         rq_q[$];
    logic [15:0] e_data   [AN];
    bit          e_dknown [AN];
    logic [3:0]  e_valid;

    function automatic void model_reset();
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        m_wr = 1'b0;
        m_rd = 1'b0;
        m_err = 0;
        rq_q.delete();
        e_valid = 4'd0;
        for (int n = 0; n < AN; n++) begin
            e_data[n] = 16'd0;
            e_dknown[n] = 1'b1;
        end
        foreach (m_known[a, b, c]) m_known[a][b][c] = 1'b0;
    endfunction

    function automatic void model_step();
        bit rdy_w;
        bit rdy_r;
        int drops;
        edge_n++;
        e_valid = 4'd0;
        for (int n = 0; n < AN; n++) begin
            foreach (rq_q[i]) begin
                if (rq_q[i].cyc + n + 1 == edge_n) begin
                    e_valid[n]  = 1'b1;
                    e_dknown[n] = m_known[rq_q[i].tag][n][rq_q[i].addr];
                    e_data[n]   = m_mem[rq_q[i].tag][n][rq_q[i].addr];
                end
            end
        end
        while (rq_q.size() > 0 && rq_q[0].cyc + AN + 1 < edge_n) void'(rq_q.pop_front());
        rdy_w = !m_full[m_wr];
        rdy_r = m_full[m_rd];
        if (mem_write_req && rdy_w) begin
            for (int n = 0; n < AN; n++) begin
                m_mem[m_wr][n][mem_write_addr]   = mem_write_data[n*DW +: DW];
                m_known[m_wr][n][mem_write_addr] = 1'b1;
            end
        end
        if (buf_read_req && rdy_r) rq_q.push_back('{edge_n, int'(buf_read_addr), m_rd});
        drops = int'(mem_write_req && !rdy_w) + int'(buf_read_req && !rdy_r);
        if (ERR_EN) m_err = (m_err + drops > 65535) ? 65535 : m_err + drops;
        if (mem_fill_done && rdy_w) begin
            m_full[m_wr] = 1'b1;
            m_wr = !m_wr;
        end
        if (buf_drain_done && rdy_r) begin
            m_full[m_rd] = 1'b0;
            m_rd = !m_rd;
        end
    endfunction

    task automatic check_outputs();
        chk("wr_ready", 64'(mem_write_ready), 64'(!m_full[m_wr]));
        chk("rd_ready", 64'(rd_bank_ready), 64'(m_full[m_rd]));
        chk("valid", 64'(buf_read_valid), 64'(e_valid));
        for (int n = 0; n < AN; n++) begin
            if (e_dknown[n]) chk($sformatf("data%0d", n), 64'(buf_read_data[n*DW +: DW]), 64'(e_data[n]));
        end
        chk("err", 64'(err_count), 64'(m_err));
    endtask

    task automatic clear_strobes();
        mem_write_req = 1'b0; mem_fill_done = 1'b0; buf_read_req = 1'b0; buf_drain_done = 1'b0;
        u2_wreq = 1'b0; u2_fill = 1'b0; u2_rreq = 1'b0; u2_drain = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        clear_strobes();
    endtask

    task automatic idle(input int k);
        repeat (k) cycle();
    endtask

    task automatic wr(input int a, input logic [63:0] d);
        mem_write_req = 1'b1; mem_write_addr = 10'(a); mem_write_data = d;
        cycle();
    endtask

    task automatic rd(input int a);
        buf_read_req = 1'b1; buf_read_addr = 10'(a);
        cycle();
    endtask

    task automatic fill();
        mem_fill_done = 1'b1;
        cycle();
    endtask

    task automatic drain();
        buf_drain_done = 1'b1;
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 64'(buf_read_valid), 64'd0);
        chk("rst_wr_ready", 64'(mem_write_ready), 64'd1);
        chk("rst_rd_ready", 64'(rd_bank_ready), 64'd0);
        chk("rst_data", buf_read_data, 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_strobes();
    endtask

    function automatic logic [63:0] tile(input int k, input int base);
        logic [63:0] d;
        d = 64'd0;
        for (int n = 0; n < AN; n++) d[n*DW +: DW] = 16'(base + k*16 + n);
        return d;
    endfunction

    logic [15:0] exp5 [AN];

    initial begin
        reset = 1'b0;
        clear_strobes();
        mem_write_addr = 10'd0; mem_write_data = 64'd0; buf_read_addr = 10'd0;
        u2_waddr = 11'd0; u2_wdata = 32'd0; u2_raddr = 10'd0;
        edge_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check_outputs();

        // Single tile, read address 2: lane n valid n+2 cycles after the request
        for (int k = 0; k < 4; k++) wr(k, tile(k, 0));
        fill();
        chk("t1_rd_ready", 64'(rd_bank_ready), 64'd1);
        rd(2);
        for (int k = 1; k <= 5; k++) begin
            cycle();
            chk("t1_valid", 64'(buf_read_valid), (k <= 4) ? 64'(1 << (k-1)) : 64'd0);
            if (k <= 4) chk("t1_data", 64'(buf_read_data[(k-1)*DW +: DW]), 64'(32 + k - 1));
        end

        // Ping-pong: fill tag1 while draining tag0
        for (int k = 0; k < 4; k++) begin
            buf_read_req = 1'b1; buf_read_addr = 10'(k);
            wr(k, tile(k, 256));
        end
        fill();
        chk("t2_wr_ready_low", 64'(mem_write_ready), 64'd0);
        idle(5);
        chk("t2_wr_ready_held", 64'(mem_write_ready), 64'd0);
        drain();
        chk("t2_wr_ready_back", 64'(mem_write_ready), 64'd1);
        rd(2);
        cycle();
        chk("t2_lane0_tag1", 64'(buf_read_data[15:0]), 64'd288);
        idle(4);

        // drain_done right after a read: the in-flight wavefront keeps its tag
        rd(3);
        drain();
        idle(3);
        chk("t3_valid3", 64'(buf_read_valid[3]), 64'd1);
        chk("t3_lane3", 64'(buf_read_data[63:48]), 64'd307);
        idle(2);

        // Dropped read and dropped write
        do_reset();
        rd(0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t4_no_valid", 64'(buf_read_valid), 64'd0);
        end
        wr(0, 64'h0D03_0D02_0D01_0D00);
        fill();
        wr(0, 64'h0E03_0E02_0E01_0E00);
        fill();
        wr(0, 64'h0F03_0F02_0F01_0F00);
        chk("t4_err", 64'(err_count), ERR_EN ? 64'd2 : 64'd0);
        rd(0);
        cycle();
        chk("t4_tag0_kept", 64'(buf_read_data[15:0]), 64'h0D00);
        idle(4);

        // Reset while the wavefront sits at lane 1
        rd(1);
        cycle();
        do_reset();
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            mem_write_req  = ($urandom_range(0, 99) < 40);
            mem_write_addr = 10'($urandom_range(0, 7));
            mem_write_data = {$urandom, $urandom};
            mem_fill_done  = ($urandom_range(0, 99) < 6);
            buf_read_req   = ($urandom_range(0, 99) < 40);
            buf_read_addr  = 10'($urandom_range(0, 7));
            buf_drain_done = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 999) == 0) do_reset();
            else cycle();
        end
        idle(6);

        // GROUP_SIZE=2 instance: buf_id=1 writes touch only lanes 2 and 3
        do_reset();
        u2_wreq = 1'b1; u2_waddr = {10'd5, 1'b0}; u2_wdata = {16'h2222, 16'h1111};
        cycle();
        u2_wreq = 1'b1; u2_waddr = {10'd5, 1'b1}; u2_wdata = {16'h4444, 16'h3333};
        cycle();
        u2_wreq = 1'b1; u2_waddr = {10'd5, 1'b1}; u2_wdata = {16'hBBBB, 16'hAAAA};
        cycle();
        u2_fill = 1'b1;
        cycle();
        chk("t5_rd_ready", 64'(u2_rready), 64'd1);
        u2_rreq = 1'b1; u2_raddr = 10'd5;
        cycle();
        exp5[0] = 16'h1111; exp5[1] = 16'h2222; exp5[2] = 16'hAAAA; exp5[3] = 16'hBBBB;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            chk("t5_valid", 64'(u2_rvalid), (k <= 4) ? 64'(1 << (k-1)) : 64'd0);
            if (k <= 4) chk($sformatf("t5_lane%0d", k-1), 64'(u2_rdata[(k-1)*DW +: DW]), 64'(exp5[k-1]));
        end
        chk("t5_err", 64'(u2_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
